// File: rtl/controle_estados_pkg.sv
// Shared encodings for the multi-cycle control sequencer and the PC block that
// consumes its estado/pcsrc/immediate outputs.
package controle_estados_pkg;

    typedef enum logic [3:0] {
        Busca      = 4'b0000,
        Decodifica = 4'b0001,
        Executa    = 4'b0010,
        Memoria    = 4'b0011,
        Escrita    = 4'b0100,
        AtualizaPc = 4'b1000
    } estado_t;

    localparam logic [6:0] OpcR      = 7'b0110011;
    localparam logic [6:0] OpcI      = 7'b0010011;
    localparam logic [6:0] OpcLoad   = 7'b0000011;
    localparam logic [6:0] OpcStore  = 7'b0100011;
    localparam logic [6:0] OpcBranch = 7'b1100011;

    localparam logic [2:0] Funct3Beq = 3'b000;
    localparam logic [2:0] Funct3Bne = 3'b001;

    localparam logic [1:0] AluOpAdd   = 2'b00;
    localparam logic [1:0] AluOpSub   = 2'b01;
    localparam logic [1:0] AluOpFunct = 2'b10;

    // Memory ops need an address add, branches a compare-by-subtract.
    function automatic logic [1:0] alu_op_de(input logic is_mem, input logic is_branch,
                                             input logic is_arit);
        if (is_mem)    return AluOpAdd;
        if (is_branch) return AluOpSub;
        if (is_arit)   return AluOpFunct;
        return AluOpAdd;
    endfunction

endpackage

// File: rtl/controle_estados_if.sv
// Datapath-facing bundle of the sequencer: instruction/zero in, state and strobes out.
interface controle_estados_if;

    logic [31:0] instrucao;
    logic        zero;
    logic [3:0]  estado;
    logic        pcsrc;
    logic [11:0] immediate;
    logic        ir_load;
    logic        reg_write;
    logic        mem_read;
    logic        mem_write;
    logic        mem_to_reg;
    logic        alu_src;
    logic [1:0]  alu_op;
    logic        ilegal;
    logic [31:0] contador_instrucoes;

    modport master (
        input  instrucao, zero,
        output estado, pcsrc, immediate, ir_load, reg_write, mem_read, mem_write,
               mem_to_reg, alu_src, alu_op, ilegal, contador_instrucoes
    );

    modport slave (
        output instrucao, zero,
        input  estado, pcsrc, immediate, ir_load, reg_write, mem_read, mem_write,
               mem_to_reg, alu_src, alu_op, ilegal, contador_instrucoes
    );

endinterface

// File: rtl/controle_estados_decodificador.sv
// Combinational instruction-class decode and B-type immediate extraction.
module controle_estados_decodificador
    import controle_estados_pkg::*;
(
    input  logic [31:0] ir,
    output logic        is_r,
    output logic        is_i,
    output logic        is_load,
    output logic        is_store,
    output logic        is_branch,
    output logic        is_ilegal,
    output logic [2:0]  funct3,
    output logic [11:0] immediate
);

    always_comb begin
        is_r      = 1'b0;
        is_i      = 1'b0;
        is_load   = 1'b0;
        is_store  = 1'b0;
        is_branch = 1'b0;
        is_ilegal = 1'b0;
        case (ir[6:0])
            OpcR:      is_r      = 1'b1;
            OpcI:      is_i      = 1'b1;
            OpcLoad:   is_load   = 1'b1;
            OpcStore:  is_store  = 1'b1;
            OpcBranch: is_branch = 1'b1;
            default:   is_ilegal = 1'b1;
        endcase
    end

    assign funct3    = ir[14:12];
    // imm[12:1]; the PC block does its own shift/sign extension.
    assign immediate = {ir[31], ir[7], ir[30:25], ir[11:8]};

    // Register specifiers are consumed by the register file, not by control.
    logic unused_campos;
    assign unused_campos = ^ir[24:15];

endmodule

// File: rtl/controle_estados.sv
// Multi-cycle control sequencer: holds IR, walks each instruction through its states and
// drives registered datapath strobes, pcsrc/immediate for the PC block and a retire counter.
module controle_estados
    import controle_estados_pkg::*;
(
    input logic               clk,
    input logic               reset,
    controle_estados_if.master bus
);

    estado_t     estado_q, estado_d;
    logic [31:0] ir_q, ir_d;
    logic        pcsrc_q;
    logic [31:0] cnt_q;
    logic [11:0] imm_q;
    logic        ir_load_q, reg_write_q, mem_read_q, mem_write_q, mem_to_reg_q;
    logic        alu_src_q, ilegal_q;
    logic [1:0]  alu_op_q;

    logic        is_r, is_i, is_load, is_store, is_branch, is_ilegal;
    logic [2:0]  funct3;
    logic [11:0] imm_d;
    logic        tomado;

    // Decoding the next IR lets every strobe be registered; outside BUSCA it equals ir_q.
    controle_estados_decodificador u_decodificador (
        .ir        (ir_d),
        .is_r      (is_r),
        .is_i      (is_i),
        .is_load   (is_load),
        .is_store  (is_store),
        .is_branch (is_branch),
        .is_ilegal (is_ilegal),
        .funct3    (funct3),
        .immediate (imm_d)
    );

    always_comb begin
        ir_d     = ir_q;
        estado_d = Busca;
        case (estado_q)
            Busca: begin
                ir_d     = bus.instrucao;
                estado_d = Decodifica;
            end
            Decodifica: estado_d = is_ilegal ? AtualizaPc : Executa;
            Executa: begin
                if (is_load || is_store) estado_d = Memoria;
                else if (is_branch)      estado_d = AtualizaPc;
                else                     estado_d = Escrita;
            end
            Memoria:    estado_d = is_load ? Escrita : AtualizaPc;
            Escrita:    estado_d = AtualizaPc;
            AtualizaPc: estado_d = Busca;
            default:    estado_d = Busca;
        endcase
    end

    always_comb begin
        tomado = 1'b0;
        if (is_branch && funct3 == Funct3Beq)      tomado = bus.zero;
        else if (is_branch && funct3 == Funct3Bne) tomado = !bus.zero;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            estado_q     <= Busca;
            ir_q         <= '0;
            pcsrc_q      <= 1'b0;
            cnt_q        <= '0;
            imm_q        <= '0;
            ir_load_q    <= 1'b1;
            reg_write_q  <= 1'b0;
            mem_read_q   <= 1'b0;
            mem_write_q  <= 1'b0;
            mem_to_reg_q <= 1'b0;
            alu_src_q    <= 1'b0;
            alu_op_q     <= AluOpAdd;
            ilegal_q     <= 1'b0;
        end else begin
            estado_q     <= estado_d;
            ir_q         <= ir_d;
            imm_q        <= imm_d;
            ir_load_q    <= (estado_d == Busca);
            reg_write_q  <= (estado_d == Escrita);
            mem_read_q   <= (estado_d == Memoria) && is_load;
            mem_write_q  <= (estado_d == Memoria) && is_store;
            mem_to_reg_q <= (estado_d == Escrita) && is_load;
            alu_src_q    <= is_i || is_load || is_store;
            alu_op_q     <= alu_op_de(is_load || is_store, is_branch, is_r || is_i);
            ilegal_q     <= (estado_d == Decodifica) && is_ilegal;

            if (estado_q == Executa)    pcsrc_q <= tomado;
            else if (estado_d == Busca) pcsrc_q <= 1'b0;

            if (estado_q == AtualizaPc) cnt_q <= cnt_q + 32'd1;
        end
    end

    assign bus.estado              = estado_q;
    assign bus.pcsrc               = pcsrc_q;
    assign bus.immediate           = imm_q;
    assign bus.ir_load             = ir_load_q;
    assign bus.reg_write           = reg_write_q;
    assign bus.mem_read            = mem_read_q;
    assign bus.mem_write           = mem_write_q;
    assign bus.mem_to_reg          = mem_to_reg_q;
    assign bus.alu_src             = alu_src_q;
    assign bus.alu_op              = alu_op_q;
    assign bus.ilegal              = ilegal_q;
    assign bus.contador_instrucoes = cnt_q;

endmodule

// File: tb/tb_controle_estados.sv
// Bench for controle_estados: directed instructions, a mid-instruction reset, counter wrap
// and random instructions, all checked against a per-instruction path model.
module tb_controle_estados;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    controle_estados_if bus ();

    controle_estados dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    typedef enum int {ClsR, ClsI, ClsLoad, ClsStore, ClsBranch, ClsIlegal} cls_t;

    int          checks   = 0;
    int          failures = 0;
    logic [31:0] held_ir;
    logic [31:0] exp_cnt;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic cls_t classify(input logic [31:0] ir);
        case (ir[6:0])
            7'b0110011: return ClsR;
            7'b0010011: return ClsI;
            7'b0000011: return ClsLoad;
            7'b0100011: return ClsStore;
            7'b1100011: return ClsBranch;
            default:    return ClsIlegal;
        endcase
    endfunction

    // {ir_load, reg_write, mem_read, mem_write, mem_to_reg, alu_src, alu_op, ilegal, pcsrc}
    function automatic logic [9:0] expect_out(input int st, input logic [31:0] ir,
                                              input logic taken);
        cls_t       c;
        logic [1:0] aop;
        c   = classify(ir);
        aop = 2'b00;
        if (c == ClsBranch)             aop = 2'b01;
        if (c == ClsR || c == ClsI)     aop = 2'b10;
        return {st == 0, st == 4, st == 3 && c == ClsLoad, st == 3 && c == ClsStore,
                st == 4 && c == ClsLoad, c == ClsI || c == ClsLoad || c == ClsStore, aop,
                st == 1 && c == ClsIlegal, st == 8 && taken};
    endfunction

    task automatic check_cycle(input string tag, input int st, input logic taken);
        logic [9:0]  mask;
        logic [9:0]  obs;
        logic [11:0] imm;
        mask = 10'h3FF;
        if (classify(held_ir) == ClsIlegal) mask[2:1] = 2'b00;
        obs = {bus.ir_load, bus.reg_write, bus.mem_read, bus.mem_write, bus.mem_to_reg,
               bus.alu_src, bus.alu_op, bus.ilegal, bus.pcsrc};
        imm = {held_ir[31], held_ir[7], held_ir[30:25], held_ir[11:8]};
        check_val({tag, "/estado"}, 32'(bus.estado), 32'(st));
        check_val({tag, "/strobes"}, 32'(obs & mask), 32'(expect_out(st, held_ir, taken) & mask));
        check_val({tag, "/imm"}, 32'(bus.immediate), 32'(imm));
        check_val({tag, "/cnt"}, bus.contador_instrucoes, exp_cnt);
    endtask

    // Runs up to `limit` cycles of one instruction, starting in BUSCA.
    task automatic run_instr(input string tag, input logic [31:0] instr, input logic z,
                             input int limit);
        int   path[$];
        cls_t c;
        logic taken;
        c    = classify(instr);
        path = {0, 1};
        if (c == ClsIlegal) path.push_back(8);
        else begin
            path.push_back(2);
            if (c == ClsLoad || c == ClsStore)         path.push_back(3);
            if (c == ClsR || c == ClsI || c == ClsLoad) path.push_back(4);
            path.push_back(8);
        end
        taken = 1'b0;
        if (c == ClsBranch && instr[14:12] == 3'b000) taken = z;
        if (c == ClsBranch && instr[14:12] == 3'b001) taken = !z;
        for (int k = 0; k < path.size() && k < limit; k++) begin
            check_cycle($sformatf("%s/c%0d", tag, k), path[k], taken);
            bus.instrucao = (path[k] == 0) ? instr : $urandom();
            bus.zero      = (path[k] == 2) ? z : 1'($urandom_range(0, 1));
            @(posedge clk);
            #1;
            if (path[k] == 0) held_ir = instr;
            if (path[k] == 8) exp_cnt = exp_cnt + 32'd1;
        end
    endtask

    initial begin
        reset         = 1'b1;
        bus.instrucao = 32'h0;
        bus.zero      = 1'b0;
        held_ir       = 32'h0;
        exp_cnt       = 32'h0;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        check_cycle("reset", 0, 1'b0);

        run_instr("addi", 32'h00500093, 1'b0, 99);
        run_instr("beq",  32'h00000463, 1'b1, 99);
        run_instr("bne",  32'h00001463, 1'b1, 99);
        run_instr("lw",   32'h00002103, 1'b0, 99);
        run_instr("sw",   32'h00202023, 1'b0, 99);
        run_instr("ill",  32'hFFFFFFFF, 1'b0, 99);
        check_val("cnt_directed", bus.contador_instrucoes, 32'd6);

        // Abort a store while its write strobe is up.
        run_instr("swabort", 32'h00202023, 1'b0, 3);
        check_cycle("swabort/mem", 3, 1'b0);
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset   = 1'b0;
        held_ir = 32'h0;
        exp_cnt = 32'h0;
        check_cycle("swabort/after", 0, 1'b0);

        force dut.cnt_q = 32'hFFFF_FFFF;
        #1;
        release dut.cnt_q;
        exp_cnt = 32'hFFFF_FFFF;
        run_instr("wrap", 32'h00500093, 1'b0, 99);
        check_val("cnt_wrap", bus.contador_instrucoes, 32'h0);

        for (int n = 0; n < 40; n++) begin
            logic [31:0] r;
            int          sel;
            r   = $urandom();
            sel = $urandom_range(0, 5);
            case (sel)
                0: r[6:0] = 7'b0110011;
                1: r[6:0] = 7'b0010011;
                2: r[6:0] = 7'b0000011;
                3: r[6:0] = 7'b0100011;
                4: begin
                    r[6:0]   = 7'b1100011;
                    r[14:12] = 3'($urandom_range(0, 3));
                end
                default: if (classify(r) != ClsIlegal) r[6:0] = 7'b1111111;
            endcase
            run_instr($sformatf("rnd%0d", n), r, 1'($urandom_range(0, 1)), 99);
        end
        check_cycle("end", 0, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
